// File: rtl/dmem_responder.sv
// Single-port data memory responder: one request at a time, a programmable
// wait of WAIT_CYCLES cycles, then a held response until it is accepted.
module dmem_responder #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_mode,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_WORD = 2'b00,
    MODE_HALF = 2'b01,
    MODE_BYTE = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef struct packed {
    logic        we;
    mode_e       mode;
    logic [11:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  req_t              req_q, req_in, acc;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              accept, enter_resp, mem_we, acc_err;
  logic [IDX_W-1:0]  word_idx;
  logic [31:0]       rd_word, load_data, wr_lanes;
  logic [3:0]        wr_be;
  logic [31:0]       mem_q [DEPTH_WORDS];

  assign req_in = '{we: req_we, mode: mode_e'(req_mode), addr: req_addr, wdata: req_wdata};

  // With WAIT_CYCLES=0 the access happens on the accept edge itself, so it
  // must see the live request rather than the not-yet-latched copy.
  assign acc      = (state_q == IDLE) ? req_in : req_q;
  assign word_idx = IDX_W'(32'(acc.addr[11:2]) % DEPTH_WORDS);
  assign rd_word  = mem_q[word_idx];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        req_q <= req_in;
      end
      if (enter_resp) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && !rst) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end

  // Access decode: alignment check, little-endian lane select and write merge.
  always_comb begin
    acc_err   = 1'b0;
    load_data = 32'd0;
    wr_be     = 4'b0000;
    wr_lanes  = acc.wdata;
    unique case (acc.mode)
      MODE_WORD: begin
        acc_err   = (acc.addr[1:0] != 2'b00);
        load_data = rd_word;
        wr_be     = 4'b1111;
      end
      MODE_HALF: begin
        acc_err   = acc.addr[0];
        load_data = {16'h0000, acc.addr[1] ? rd_word[31:16] : rd_word[15:0]};
        wr_be     = acc.addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes  = {2{acc.wdata[15:0]}};
      end
      MODE_BYTE: begin
        load_data = {24'h000000, rd_word[{acc.addr[1:0], 3'b000} +: 8]};
        wr_be     = 4'b0001 << acc.addr[1:0];
        wr_lanes  = {4{acc.wdata[7:0]}};
      end
      default: acc_err = 1'b1;
    endcase
    rdata_d = (acc.we || acc_err) ? 32'd0 : load_data;
    err_d   = acc_err;
    mem_we  = enter_resp && !rst && acc.we && !acc_err;
  end

  // NOTE: the storage array has no reset; contents survive rst and the
  // array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem_q[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, giving extra access-latency cycles (0..15).
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit storage words (4 KB byte space).
REQ-003 SHALL use one clock; reset is asynchronous and active-high; ports are named clk and rst.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req_valid  input  1  requester presents an access.
REQ-007 req_ready  output  1  responder can accept an access.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_mode  input  2  access size: 00 word, 01 halfword, 10 byte, 11 reserved.
REQ-010 req_addr  input  12  byte address.
REQ-011 req_wdata  input  32  store data, right-justified.
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  requester accepts the response.
REQ-014 resp_rdata  output  32  load data, right-justified, zero-extended.
REQ-015 resp_err  output  1  access rejected (misaligned or reserved mode).

Function
REQ-016 SHALL implement FSM states IDLE, BUSY and RESP.
REQ-017 IDLE: req_ready=1; resp_valid=0.
REQ-018 BUSY and RESP: req_ready=0.
REQ-019 A request SHALL be accepted only on a clk edge with req_valid=1 and req_ready=1; req_we, req_mode, req_addr and req_wdata are latched at that edge.
REQ-020 On accept with WAIT_CYCLES=0: next state RESP. Otherwise: next state BUSY with the wait counter loaded to WAIT_CYCLES-1.
REQ-021 BUSY: the counter decrements each cycle; the edge on which the counter equals 0 moves the state to RESP.
REQ-022 Latency SHALL be exactly WAIT_CYCLES+1 cycles from the accept edge to resp_valid=1.
REQ-023 The memory access (read sample or write) SHALL occur on the edge that enters RESP.
REQ-024 resp_rdata and resp_err SHALL be registered on that same edge and held stable while in RESP.
REQ-025 RESP: resp_valid=1 until an edge with resp_ready=1; that edge returns the state to IDLE.
REQ-026 No new request is accepted on the response-handshake edge; the next accept is possible one cycle later.
REQ-027 Byte lanes SHALL be little-endian: addr[1:0]=0 selects bits 7:0, addr[1:0]=3 selects bits 31:24.
REQ-028 Word index SHALL be addr[11:2] modulo DEPTH_WORDS.
REQ-029 Byte store: writes req_wdata[7:0] into the addressed lane only.
REQ-030 Halfword store: writes req_wdata[15:0] into lanes addr[1]*2 and addr[1]*2+1.
REQ-031 Word store: writes all 32 bits.
REQ-032 Loads SHALL return the selected lane(s) right-justified with upper bits 0.
REQ-033 Stores SHALL return resp_rdata=0.
REQ-034 Error (resp_err=1) SHALL be raised for: mode 11, halfword with addr[0]=1, or word with addr[1:0]!=00.
REQ-035 On error: no memory write occurs, resp_rdata=0, and the full handshake and latency still apply.
REQ-036 Input changes outside the accept edge SHALL have no effect on the access in flight.

Reset
REQ-037 While rst=1: state=IDLE, counter=0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-038 Reset asserted in BUSY or RESP SHALL abort the access with no memory write and no response.
REQ-039 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-040 WAIT_CYCLES=1: store word 0x12345678 @0x010, then load word @0x010 -> resp_valid 2 cycles after each accept, rdata=0x12345678, err=0.
REQ-041 Store byte 0xAB @0x011 over 0x12345678, then load word @0x010 -> 0x1234AB78; load byte @0x011 -> 0x000000AB; load half @0x012 -> 0x00001234.
REQ-042 Load half @0x013 and a request with mode 11 -> err=1, rdata=0; a following word load @0x010 shows memory unchanged.
REQ-043 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, rdata and err stable and req_ready=0 throughout; release -> IDLE on the next edge.
REQ-044 Assert rst during BUSY of a word store 0xFFFFFFFF @0x020 -> outputs at reset values, and a later load @0x020 returns the prior contents.
REQ-045 WAIT_CYCLES=0 with back-to-back requests and resp_ready=1 -> one response every 2 cycles, latency 1.
